// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: clock inhibit, request-to-send, 8 data bits,
// odd parity and stop shifted out on device clock falls, then acknowledge check.
module ps2_host_tx #(
  parameter int CLK_HZ         = 16_000_000,
  parameter int INHIBIT_CYCLES = 1600,
  parameter int TIMEOUT_CYCLES = 240_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       kbd_clk_in,
  input  logic       kbd_data_in,
  output logic       kbd_clk_oe,
  output logic       kbd_data_oe,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam int INH_W = $clog2(INHIBIT_CYCLES) + 1;
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES) + 1;

  if (CLK_HZ <= 0) begin : g_bad_clk_hz
    $error("CLK_HZ must be positive");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_REQ,
    S_SEND,
    S_ACK,
    S_RELEASE
  } state_t;

  state_t           state;
  logic             clk_sync_p0, clk_sync_p1, clk_dly_p2;
  logic             data_sync_p0, data_sync_p1;
  logic             fall;
  logic             accept;
  logic             timeout;
  logic [7:0]       shift;
  logic             parity;
  logic             ack_fail;
  logic [3:0]       bit_n;
  logic [INH_W-1:0] icnt;
  logic [TO_W-1:0]  tcnt;

  // Pin synchronizers; idle bus level is high, so they reset to 1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync_p0  <= 1'b1;
      clk_sync_p1  <= 1'b1;
      clk_dly_p2   <= 1'b1;
      data_sync_p0 <= 1'b1;
      data_sync_p1 <= 1'b1;
    end else begin
      clk_sync_p0  <= kbd_clk_in;
      clk_sync_p1  <= clk_sync_p0;
      clk_dly_p2   <= clk_sync_p1;
      data_sync_p0 <= kbd_data_in;
      data_sync_p1 <= data_sync_p0;
    end
  end

  assign fall    = clk_dly_p2 & ~clk_sync_p1;
  assign accept  = (state == S_IDLE) && tx_valid && tx_ready;
  assign timeout = (tcnt == TO_W'(TIMEOUT_CYCLES));

  // Payload registers carry no reset; they are only read after an accept
  always_ff @(posedge clk) begin
    if (accept) begin
      shift  <= tx_data;
      parity <= ~^tx_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      kbd_clk_oe  <= 1'b0;
      kbd_data_oe <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      tx_ready    <= 1'b1;
      ack_fail    <= 1'b0;
      bit_n       <= '0;
      icnt        <= '0;
      tcnt        <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          kbd_clk_oe  <= 1'b0;
          kbd_data_oe <= 1'b0;
          tx_ready    <= 1'b1;
          if (accept) begin
            state      <= S_INHIBIT;
            kbd_clk_oe <= 1'b1;
            busy       <= 1'b1;
            tx_ready   <= 1'b0;
            icnt       <= '0;
          end
        end
        S_INHIBIT: begin
          icnt <= icnt + 1'b1;
          if (icnt == INH_W'(INHIBIT_CYCLES - 1)) begin
            state       <= S_REQ;
            kbd_data_oe <= 1'b1;
          end
        end
        S_REQ: begin
          // Start bit stays on data while the clock is handed to the device
          state      <= S_SEND;
          kbd_clk_oe <= 1'b0;
          bit_n      <= '0;
          tcnt       <= '0;
        end
        S_SEND, S_ACK, S_RELEASE: begin
          if (timeout) begin
            state       <= S_IDLE;
            kbd_clk_oe  <= 1'b0;
            kbd_data_oe <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b1;
            err         <= 1'b1;
          end else begin
            if (fall) tcnt <= '0;
            else      tcnt <= tcnt + 1'b1;
            if (state == S_SEND && fall) begin
              if (bit_n < 4'd8)       kbd_data_oe <= ~shift[bit_n[2:0]];
              else if (bit_n == 4'd8) kbd_data_oe <= ~parity;
              else                    kbd_data_oe <= 1'b0;
              bit_n <= bit_n + 1'b1;
              if (bit_n == 4'd9) state <= S_ACK;
            end else if (state == S_ACK && fall) begin
              ack_fail <= data_sync_p1;
              state    <= S_RELEASE;
            end else if (state == S_RELEASE && clk_sync_p1 && data_sync_p1) begin
              state <= S_IDLE;
              busy  <= 1'b0;
              done  <= 1'b1;
              err   <= ack_fail;
            end
          end
        end
        default: begin
          state       <= S_IDLE;
          kbd_clk_oe  <= 1'b0;
          kbd_data_oe <= 1'b0;
          busy        <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-collector bus with a PS/2 device model and a
// scoreboard of expected command frames.
module tb_ps2_host_tx;

  localparam int INH = 1600;
  localparam int TO  = 3000;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, kbd_clk_oe, kbd_data_oe, busy, done, err;
  logic       kbd_clk_in, kbd_data_in;
  logic       dev_clk_pull = 1'b0;
  logic       dev_data_pull = 1'b0;

  assign kbd_clk_in  = ~(kbd_clk_oe | dev_clk_pull);
  assign kbd_data_in = ~(kbd_data_oe | dev_data_pull);

  always #5 clk = ~clk;

  ps2_host_tx #(
    .CLK_HZ(16_000_000),
    .INHIBIT_CYCLES(INH),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .tx_data(tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .kbd_clk_in(kbd_clk_in),
    .kbd_data_in(kbd_data_in),
    .kbd_clk_oe(kbd_clk_oe),
    .kbd_data_oe(kbd_data_oe),
    .busy(busy),
    .done(done),
    .err(err)
  );

  typedef struct {
    logic [7:0] data;
    logic       err;
  } exp_t;

  exp_t       exp_q[$];
  int         n_tests = 0;
  int         n_fail = 0;
  int         n_done = 0;
  logic       done_seen = 1'b0;
  logic       err_seen = 1'b0;
  logic [1:0] oe_seen = 2'b00;

  // Advance n cycles (sampling on falling edges) and latch any done pulse
  task automatic tick_watch(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (done) begin
        done_seen = 1'b1;
        err_seen  = err;
        oe_seen   = {kbd_clk_oe, kbd_data_oe};
        n_done++;
      end
    end
  endtask

  task automatic send_cmd(input logic [7:0] d, input logic e);
    exp_t x;
    int   t;
    x.data = d;
    x.err  = e;
    exp_q.push_back(x);
    @(negedge clk);
    tx_data   = d;
    tx_valid  = 1'b1;
    done_seen = 1'b0;
    t = 0;
    while (!busy && t < 100) begin
      tick_watch(1);
      t++;
    end
    tx_valid = 1'b0;
    n_tests++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL accept: busy=%b required 1", busy);
    end
  endtask

  // Device model: clock with the given half period, optionally acknowledge;
  // abort_after > 0 returns with the clock held low after that many falls.
  task automatic dev_frame(input int half, input bit ack, input int abort_after,
                           output logic [9:0] bits);
    int t;
    int inh;
    bits = '0;
    t = 0;
    while (!kbd_clk_oe && t < 200) begin
      tick_watch(1);
      t++;
    end
    inh = 0;
    while (kbd_clk_oe && !kbd_data_oe && inh < INH + 100) begin
      inh++;
      tick_watch(1);
    end
    n_tests++;
    if (inh != INH) begin
      n_fail++;
      $display("FAIL inhibit_len: got %0d cycles required %0d", inh, INH);
    end
    t = 0;
    while (kbd_clk_oe && t < 10) begin
      tick_watch(1);
      t++;
    end
    n_tests++;
    if (kbd_data_in !== 1'b0 || kbd_clk_in !== 1'b1) begin
      n_fail++;
      $display("FAIL start_bit: clk=%b data=%b required clk=1 data=0", kbd_clk_in, kbd_data_in);
    end
    for (int i = 0; i < 10; i++) begin
      tick_watch(half);
      dev_clk_pull = 1'b1;
      tick_watch(half);
      if (abort_after == i + 1) return;
      dev_clk_pull = 1'b0;
      bits[i] = kbd_data_in;
    end
    tick_watch(half / 2);
    dev_data_pull = ack;
    tick_watch(half - half / 2);
    dev_clk_pull = 1'b1;
    tick_watch(half);
    dev_clk_pull = 1'b0;
    tick_watch(2);
    dev_data_pull = 1'b0;
  endtask

  task automatic finish_frame(input logic [9:0] bits, input bit check_idle);
    exp_t x;
    int   t;
    t = 0;
    while (!done_seen && t < 2 * TO) begin
      tick_watch(1);
      t++;
    end
    n_tests++;
    if (!done_seen || exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL done: seen=%b queued=%0d required done with a queued frame", done_seen, exp_q.size());
      return;
    end
    x = exp_q.pop_front();
    n_tests += 5;
    if (bits[7:0] !== x.data) begin
      n_fail++;
      $display("FAIL byte: got %h required %h", bits[7:0], x.data);
    end
    if (bits[8] !== ~^x.data) begin
      n_fail++;
      $display("FAIL parity: got %b required %b", bits[8], ~^x.data);
    end
    if (bits[9] !== 1'b1) begin
      n_fail++;
      $display("FAIL stop: got %b required 1", bits[9]);
    end
    if (err_seen !== x.err) begin
      n_fail++;
      $display("FAIL err: got %b required %b", err_seen, x.err);
    end
    if (oe_seen !== 2'b00) begin
      n_fail++;
      $display("FAIL oe_at_done: got %b required 00", oe_seen);
    end
    if (check_idle) begin
      tick_watch(1);
      n_tests++;
      if (busy !== 1'b0 || tx_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL idle_after: busy=%b tx_ready=%b required 0/1", busy, tx_ready);
      end
    end
    done_seen = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++;
    if ({kbd_clk_oe, kbd_data_oe, busy, done, err, tx_ready} !== 6'b000001) begin
      n_fail++;
      $display("FAIL reset_vals: clk_oe,data_oe,busy,done,err,ready=%b required 000001",
               {kbd_clk_oe, kbd_data_oe, busy, done, err, tx_ready});
    end
    rst_n = 1'b1;
    tick_watch(3);
  endtask

  task automatic test_ed;
    logic [9:0] b;
    send_cmd(8'hED, 1'b0);
    dev_frame(640, 1'b1, 0, b);
    finish_frame(b, 1'b1);
  endtask

  task automatic test_parity_01;
    logic [9:0] b;
    send_cmd(8'h01, 1'b0);
    dev_frame(100, 1'b1, 0, b);
    n_tests++;
    if (b[8] !== 1'b0) begin
      n_fail++;
      $display("FAIL parity_01: got %b required 0", b[8]);
    end
    finish_frame(b, 1'b1);
  endtask

  task automatic test_timeout;
    exp_t x;
    int   t;
    int   c;
    send_cmd(8'h12, 1'b1);
    t = 0;
    while (kbd_clk_oe && t < INH + 50) begin
      tick_watch(1);
      t++;
    end
    c = 0;
    while (!done_seen && c < TO + 100) begin
      tick_watch(1);
      c++;
    end
    x = exp_q.pop_front();
    n_tests += 3;
    if (!done_seen || c < TO - 2 || c > TO + 2) begin
      n_fail++;
      $display("FAIL timeout_len: done=%b after %0d cycles required about %0d", done_seen, c, TO);
    end
    if (err_seen !== x.err) begin
      n_fail++;
      $display("FAIL timeout_err: got %b required %b", err_seen, x.err);
    end
    if (oe_seen !== 2'b00) begin
      n_fail++;
      $display("FAIL timeout_oe: got %b required 00", oe_seen);
    end
    tick_watch(1);
    n_tests++;
    if (tx_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_ready: got %b required 1", tx_ready);
    end
    done_seen = 1'b0;
  endtask

  task automatic test_nack;
    logic [9:0] b;
    send_cmd(8'h3C, 1'b1);
    dev_frame(100, 1'b0, 0, b);
    finish_frame(b, 1'b1);
  endtask

  task automatic test_back_to_back;
    logic [9:0] b;
    exp_t       x;
    int         t;
    int         d0;
    x.data = 8'hFF;
    x.err  = 1'b0;
    exp_q.push_back(x);
    x.data = 8'h55;
    exp_q.push_back(x);
    @(negedge clk);
    tx_data   = 8'hFF;
    tx_valid  = 1'b1;
    done_seen = 1'b0;
    t = 0;
    while (!busy && t < 100) begin
      tick_watch(1);
      t++;
    end
    tx_data = 8'h55;
    dev_frame(100, 1'b1, 0, b);
    finish_frame(b, 1'b0);
    t = 0;
    while (!busy && t < 20) begin
      tick_watch(1);
      t++;
    end
    tx_valid = 1'b0;
    dev_frame(100, 1'b1, 0, b);
    finish_frame(b, 1'b1);
    d0 = n_done;
    tick_watch(50);
    n_tests++;
    if (busy !== 1'b0 || n_done != d0) begin
      n_fail++;
      $display("FAIL extra_frame: busy=%b extra done=%0d required 0/0", busy, n_done - d0);
    end
  endtask

  task automatic test_reset_mid;
    logic [9:0] b;
    send_cmd(8'hAA, 1'b0);
    void'(exp_q.pop_back());
    dev_frame(100, 1'b1, 5, b);
    n_tests++;
    if (kbd_data_oe !== 1'b1) begin
      n_fail++;
      $display("FAIL bit4_drive: data_oe=%b required 1", kbd_data_oe);
    end
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({kbd_clk_oe, kbd_data_oe, done} !== 3'b000) begin
      n_fail++;
      $display("FAIL async_release: clk_oe,data_oe,done=%b required 000",
               {kbd_clk_oe, kbd_data_oe, done});
    end
    done_seen = 1'b0;
    tick_watch(1);
    dev_clk_pull = 1'b0;
    tick_watch(5);
    rst_n = 1'b1;
    tick_watch(20);
    n_tests++;
    if (done_seen !== 1'b0 || busy !== 1'b0 || tx_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL post_reset: done_seen=%b busy=%b ready=%b required 0/0/1",
               done_seen, busy, tx_ready);
    end
    send_cmd(8'hF4, 1'b0);
    dev_frame(100, 1'b1, 0, b);
    finish_frame(b, 1'b1);
  endtask

  initial begin
    test_reset;
    test_ed;
    test_parity_01;
    test_timeout;
    test_nack;
    test_back_to_back;
    test_reset_mid;
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_left: %0d frames outstanding required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ps2_host_tx.md
# ps2_host_tx

PS/2 host-to-device transmitter that sends command bytes to the keyboard, such as 0xED (set LEDs) and 0xFF (reset), over the same two open-collector lines the keyboard receiver listens on. It performs the clock-inhibit / request-to-send sequence and shifts out 8 data bits, odd parity and stop. It then checks the device's acknowledge bit. The block sits beside the receiver under `top`. The board wrapper turns its output enables into tristate pulls on the clock and data pins. The receiver must ignore the lines while `busy` is high.

## Interface
- `CLK_HZ`, 16_000_000, system clock frequency.
- `INHIBIT_CYCLES`, 1600, clock-low inhibit time in cycles (100 µs at 16 MHz).
- `TIMEOUT_CYCLES`, 240_000, maximum cycles without a device clock falling edge before the frame aborts (15 ms).
- `clk` in 1: system clock; all logic on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `tx_data` in 8: command byte; sampled on accept.
- `tx_valid` in 1: request to send `tx_data`.
- `tx_ready` in 1-bit out: high only in IDLE.
- `kbd_clk_in` in 1: raw PS/2 clock pin level (asynchronous).
- `kbd_data_in` in 1: raw PS/2 data pin level (asynchronous).
- `kbd_clk_oe` out 1: 1 = pull clock low, 0 = release.
- `kbd_data_oe` out 1: 1 = pull data low, 0 = release.
- `busy` out 1: high from accept until `done`.
- `done` out 1: one-cycle pulse at the end of every frame.
- `err` out 1: valid with `done`; 1 = no acknowledge or timeout.

## Operation
- Pin inputs pass through a 2-flop synchronizer, then a delay register. `fall` = delayed 1 and synchronized 0. A pin change is visible as `fall` 3 cycles later.
- Handshake: the transfer is accepted when `tx_valid && tx_ready`. The byte is latched into the shift register. Odd parity = ~^tx_data, latched at the same time. `tx_valid` in any other state is ignored.
- States and transitions:
  - IDLE: both oe = 0. Accept → INHIBIT.
  - INHIBIT: `kbd_clk_oe`=1, `kbd_data_oe`=0 for exactly INHIBIT_CYCLES cycles → REQ.
  - REQ: one cycle with both oe = 1. This is the start bit on data. → SEND.
  - SEND: `kbd_clk_oe`=0, so the clock is released. Bit counter n starts at 0. On each `fall`:
    - For n=0..7, `kbd_data_oe` = ~tx_data[n].
    - For n=8, `kbd_data_oe` = ~parity.
    - For n=9, `kbd_data_oe` = 0 (stop; data released).
    - n increments after each `fall`. After the n=9 fall → ACK.
  - ACK: on the next `fall`, sample synchronized data: 0 = acknowledged, 1 = ack failure. → RELEASE.
  - RELEASE: wait until synchronized clock and data are both 1 → IDLE, with a `done` pulse and `err` = ack failure.
- Timeout: a counter is cleared on entry to SEND and on every `fall`. It counts in SEND, ACK and RELEASE. When it reaches TIMEOUT_CYCLES:
  - both oe = 0 in the same cycle as `done`=1 and `err`=1;
  - state → IDLE.
- Counter widths: `$clog2` of the respective parameter plus 1. No wrap occurs, because counting stops at the terminal value.
- A `fall` in IDLE, INHIBIT or REQ is ignored.
- `busy` = (state != IDLE).

## Timing
- Reset values: state IDLE, `kbd_clk_oe`=0, `kbd_data_oe`=0, `busy`=0, `done`=0, `err`=0, `tx_ready`=1.
- Reset mid-frame: both lines are released asynchronously and immediately. No `done` pulse is generated.
- Accept at cycle A:
  - `kbd_clk_oe`=1 during cycles A+1 .. A+INHIBIT_CYCLES.
  - REQ at cycle A+INHIBIT_CYCLES+1.
  - Clock released at cycle A+INHIBIT_CYCLES+2.
- Data-bit update: `kbd_data_oe` changes in the cycle after `fall` is high, i.e. 4 cycles after the pin edge. This is well inside the device's clock-low half period (≥30 µs).
- `done` and `err` are registered outputs. `tx_ready` returns to 1 in the cycle after `done`. Back-to-back commands are therefore spaced by at least 1 IDLE cycle.
- `err` holds its value until the next `done`.

## Test plan
- Send 0xED with a device model that clocks at 12.5 kHz and acknowledges:
  - pin inhibit lasts 1600 cycles, then start bit 0;
  - data line samples at rising edges read 1,0,1,1,0,1,1,1, then parity 1, then stop 1;
  - `done`=1, `err`=0.
- Send 0x01: the sampled parity bit is 0. The acknowledged frame gives `err`=0 and `busy`=0 afterwards.
- Device never clocks after REQ: after TIMEOUT_CYCLES, both oe = 0, `done`=1 and `err`=1 in the same cycle. Then `tx_ready`=1.
- Device clocks all 11 edges but leaves data high at the 11th fall: `done`=1, `err`=1.
- Hold `tx_valid`=1 with 0x55 throughout a 0xFF frame: exactly one frame (0xFF) is sent, then a second frame sends 0x55 after IDLE.
- Assert `rst_n`=0 during SEND bit 4: both oe drop to 0 without waiting for a clock edge, and no `done` is generated. After release, 0xF4 sends correctly.
